// File: rtl/rx_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_uart_pkg
// Description : Shared definitions for the 8N1 UART pair: receiver state
//               encoding and default link timing, so that tx_uart and rx_uart
//               stay matched.
// Revision    : 1.0  initial release
// ============================================================================
package rx_uart_pkg;

  // Default link timing: 100 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLOCKS_PER_BAUD = 868;
  localparam int DEFAULT_TIMER_BITS      = 32;

  // Bits per character (data only, start/stop handled by the FSM).
  localparam int DATA_BITS = 8;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // 1->0 transition between the previous and current synchronised samples.
  function automatic logic falling_edge(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_uart_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input, with a
//               parameterised reset value (use 1 for idle-high serial lines).
// Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic i_reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_uart.sv
`default_nettype none
// ============================================================================
// Module      : rx_uart
// Description : 8N1 serial receiver. Synchronises the line, validates the
//               start bit at mid-bit, samples 8 data bits LSB-first and the
//               stop bit, and holds the byte under a valid/read handshake.
//               Flags overrun (sticky) and framing error (one-cycle pulse).
// Revision    : 1.0  initial release
// ============================================================================
module rx_uart
  import rx_uart_pkg::*;
#(
  parameter int TIMER_BITS      = DEFAULT_TIMER_BITS,
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       uart_txd_in,
  input  logic       i_read,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy
);

  // Reload values: half a bit to reach mid-start, a full bit between samples.
  localparam logic [TIMER_BITS-1:0] HALF_RELOAD = TIMER_BITS'((CLOCKS_PER_BAUD >> 1) - 1);
  localparam logic [TIMER_BITS-1:0] FULL_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [TIMER_BITS-1:0] ONE         = TIMER_BITS'(1);
  localparam logic [2:0]            LAST_BIT    = 3'(DATA_BITS - 1);

  rx_state_t             state;
  rx_state_t             next_state;
  logic [TIMER_BITS-1:0] counter;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic                  line_sync;
  logic                  line_prev;
  logic                  line_fall;
  logic                  cnt_zero;
  logic                  load_half;
  logic                  load_full;
  logic                  shift_en;
  logic                  frame_end;
  logic                  stop_done;
  logic                  stop_ok;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (clk),
    .i_reset  (i_reset),
    .async_in (uart_txd_in),
    .sync_out (line_sync)
  );

  // Delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk) begin
    if (i_reset) line_prev <= 1'b1;
    else         line_prev <= line_sync;
  end

  assign line_fall = falling_edge(line_sync, line_prev);
  assign cnt_zero  = (counter == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  // FSM next-state and datapath control.
  always_comb begin
    next_state = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only a fresh 1->0 edge starts a frame; a line held low is ignored.
        if (line_fall) begin
          load_half  = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (!line_sync) begin
            load_full  = 1'b1;
            next_state = ST_DATA;
          end else begin
            // Line back high at mid-start: treat as a glitch.
            next_state = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_idx == LAST_BIT) next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start edge is caught.
        if (cnt_zero) begin
          frame_end  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Baud counter: reloaded at each sample point, counts down in between.
  always_ff @(posedge clk) begin
    if (i_reset)                          counter <= '0;
    else if (load_half)                   counter <= HALF_RELOAD;
    else if (load_full)                   counter <= FULL_RELOAD;
    else if (state != ST_IDLE && !cnt_zero) counter <= counter - ONE;
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (load_half)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shift   <= {line_sync, shift[7:1]};
    end
  end

  // Capture the stop sample; results are applied on the following edge.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      stop_done <= 1'b0;
      stop_ok   <= 1'b0;
    end else begin
      stop_done <= frame_end;
      stop_ok   <= line_sync;
    end
  end

  // Output hold, handshake, overrun and framing-error pulse.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_busy      <= (state != ST_IDLE);
      o_frame_err <= stop_done && !stop_ok;
      if (stop_done && stop_ok) begin
        // Delivery wins over a same-cycle read; newest data always kept.
        o_data  <= shift;
        o_valid <= 1'b1;
        if (o_valid && i_read)       o_overrun <= 1'b0;
        else if (o_valid && !i_read) o_overrun <= 1'b1;
      end else if (i_read && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_uart
// Description : Scoreboard bench for rx_uart at 16 clocks per bit. Stimulus
//               pushes the expected output state for each frame end; a
//               monitor compares it whenever o_busy falls.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_uart;

  localparam int CPB = 16;

  typedef struct {
    logic       ferr;
    logic       valid;
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       rx_line = 1'b1;
  logic       i_read = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overrun;
  logic       o_frame_err;
  logic       o_busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rx_uart #(
    .TIMER_BITS      (32),
    .CLOCKS_PER_BAUD (CPB)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .uart_txd_in (rx_line),
    .i_read      (i_read),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Count rising edges so stimulus can locate exact cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic ferr, input logic valid, input logic [7:0] data, input logic ovr);
    exp_t e;
    e.ferr = ferr; e.valid = valid; e.data = data; e.ovr = ovr;
    sb.push_back(e);
  endtask

  // Drive one 8N1 frame. Optionally assert i_read in the delivery cycle,
  // check exact busy/valid timing, or abort with reset at loop index abort_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit read_at_delivery, input bit chk_timing,
                            input int abort_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        i_reset = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        break;
      end
      rx_line = frame[i / CPB];
      i_read  = read_at_delivery && (i == 155);
      if (chk_timing) begin
        if (i == 3)   check("busy_low_at_E",     32'(o_busy),  32'd0);
        if (i == 4)   check("busy_high_at_E+1",  32'(o_busy),  32'd1);
        if (i == 155) check("valid_low_at_E+152", 32'(o_valid), 32'd0);
        if (i == 156) check("valid_high_at_E+153", 32'(o_valid), 32'd1);
      end
    end
    @(negedge clk);
    rx_line = 1'b1;
    i_read  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    i_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
    check("read_clears_valid",   32'(o_valid),   32'd0);
    check("read_clears_overrun", 32'(o_overrun), 32'd0);
  endtask

  // Monitor: every frame end (busy falling) pops one expected output state.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !o_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_end: got busy fall with empty queue, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("sb_frame_err", 32'(o_frame_err), 32'(e.ferr));
          check("sb_valid",     32'(o_valid),     32'(e.valid));
          check("sb_data",      32'(o_data),      32'(e.data));
          check("sb_overrun",   32'(o_overrun),   32'(e.ovr));
        end
      end
      prev_busy = o_busy;
    end
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("reset_data",      32'(o_data),      32'h00);
    check("reset_valid",     32'(o_valid),     32'd0);
    check("reset_overrun",   32'(o_overrun),   32'd0);
    check("reset_frame_err", 32'(o_frame_err), 32'd0);
    check("reset_busy",      32'(o_busy),      32'd0);
    idle(CPB);

    // Clean frame with exact timing, held until read.
    push(1'b0, 1'b1, 8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    idle(2 * CPB);
    check("a5_held_valid", 32'(o_valid), 32'd1);
    check("a5_held_data",  32'(o_data),  32'hA5);
    read_pulse();

    // Glitch: 4 clocks low, then a good frame.
    push(1'b0, 1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    rx_line = 1'b0;
    idle(4);
    rx_line = 1'b1;
    idle(2 * CPB);
    push(1'b0, 1'b1, 8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    idle(CPB);
    read_pulse();

    // Framing error, then a good frame.
    push(1'b1, 1'b0, 8'h5A, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    check("frame_err_one_cycle", 32'(o_frame_err), 32'd0);
    idle(2 * CPB);
    push(1'b0, 1'b1, 8'h55, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
    idle(CPB);
    read_pulse();

    // Overrun, then delivery in the same cycle as a read clears it.
    push(1'b0, 1'b1, 8'h11, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    idle(CPB);
    push(1'b0, 1'b1, 8'h22, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
    idle(CPB);
    push(1'b0, 1'b1, 8'h33, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, -1);
    idle(CPB);
    read_pulse();

    // Loopback-style frame as tx_uart would send {1, C3, 0}; left unread.
    push(1'b0, 1'b1, 8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, -1);
    idle(CPB);

    // Reset during data bit 3 aborts the frame; then a good frame.
    push(1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 4 * CPB + 8);
    idle(2 * CPB);
    push(1'b0, 1'b1, 8'hF0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, -1);
    idle(4 * CPB);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
